// File: rtl/pcu_csr_hazard_pkg.sv
// Shared definitions for the PCU CSR/hazard slice.
// Contents: RV32I opcode constants, forward-select encoding, CSR addresses,
// and decode helpers (rd writer test, operand usage, forward-source pick).
package pcu_csr_hazard_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FWD_RF  = 3'd0,
    FWD_MEM = 3'd1,
    FWD_WB  = 3'd2
  } fwd_sel_e;

  localparam logic [11:0] CSR_MTEVC  = 12'h305;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
  localparam logic [11:0] CSR_MIPD   = 12'h100;
  localparam logic [11:0] CSR_BS     = 12'h000;

  // True when the instruction architecturally writes a non-zero rd.
  function automatic logic writes_rd(input logic [XLEN-1:0] ins);
    logic w_s;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: w_s = 1'b1;
      OPC_SYSTEM:                   w_s = (ins[14:12] != 3'd0);
      default:                      w_s = 1'b0;
    endcase
    return w_s && (ins[11:7] != 5'd0);
  endfunction

  // Register-sourced rs1 reads (CSR immediate forms take rs1 as a constant).
  function automatic logic reads_rs1(input logic [XLEN-1:0] ins);
    logic r_s;
    case (ins[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
      OPC_JALR, OPC_BRANCH: r_s = 1'b1;
      OPC_SYSTEM:           r_s = (ins[14:12] inside {3'd1, 3'd2, 3'd3});
      default:              r_s = 1'b0;
    endcase
    return r_s;
  endfunction

  function automatic logic reads_rs2(input logic [XLEN-1:0] ins);
    logic r_s;
    case (ins[6:0])
      OPC_OP, OPC_STORE, OPC_BRANCH: r_s = 1'b1;
      default:                       r_s = 1'b0;
    endcase
    return r_s;
  endfunction

  // Youngest producer wins; a load in MEM has no data yet, so it is skipped.
  function automatic fwd_sel_e fwd_pick(input logic [XLEN-1:0] mem_ins,
                                        input logic [XLEN-1:0] wb_ins,
                                        input logic [4:0]      rs);
    fwd_sel_e f_s;
    if (writes_rd(mem_ins) && (mem_ins[6:0] != OPC_LOAD) && (mem_ins[11:7] == rs)) begin
      f_s = FWD_MEM;
    end else if (writes_rd(wb_ins) && (wb_ins[11:7] == rs)) begin
      f_s = FWD_WB;
    end else begin
      f_s = FWD_RF;
    end
    return f_s;
  endfunction

endpackage

// File: rtl/pcu_csr_hazard_if.sv
// Bus bundle between the PCU/datapath and the CSR+hazard core.
// slave  : the core (consumes CSR next-values and pipeline words, drives
//          CSR contents, forward selects and pipeline enables).
// master : the PCU/datapath side.
interface pcu_csr_hazard_if;
  import pcu_csr_hazard_pkg::*;

  logic            csr_we;
  logic [XLEN-1:0] mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din;
  logic [XLEN-1:0] mtevc_dout, mcause_dout, mepc_dout, mtval_dout, mipd_dout, bs_dout;
  logic [11:0]     csr_debug_addr;
  logic [XLEN-1:0] csr_debug_dout;
  logic [XLEN-1:0] id_is, ex_is, mem_is, wb_is;
  logic [2:0]      npc_mux_sel;
  logic [2:0]      b_sr1_mux_sel_fh, b_sr2_mux_sel_fh;
  logic [2:0]      sr1_mux_sel_fh, sr2_mux_sel_fh;
  logic [2:0]      dm_sr2_mux_sel_fh, csr_mux_sel_fh;
  logic            pc_en, if_id_en, id_ex_clear;

  modport slave (
    input  csr_we, mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din,
    output mtevc_dout, mcause_dout, mepc_dout, mtval_dout, mipd_dout, bs_dout,
    input  csr_debug_addr,
    output csr_debug_dout,
    input  id_is, ex_is, mem_is, wb_is, npc_mux_sel,
    output b_sr1_mux_sel_fh, b_sr2_mux_sel_fh, sr1_mux_sel_fh, sr2_mux_sel_fh,
    output dm_sr2_mux_sel_fh, csr_mux_sel_fh, pc_en, if_id_en, id_ex_clear
  );

  modport master (
    output csr_we, mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din,
    input  mtevc_dout, mcause_dout, mepc_dout, mtval_dout, mipd_dout, bs_dout,
    output csr_debug_addr,
    input  csr_debug_dout,
    output id_is, ex_is, mem_is, wb_is, npc_mux_sel,
    input  b_sr1_mux_sel_fh, b_sr2_mux_sel_fh, sr1_mux_sel_fh, sr2_mux_sel_fh,
    input  dm_sr2_mux_sel_fh, csr_mux_sel_fh, pc_en, if_id_en, id_ex_clear
  );
endinterface

// File: rtl/pcu_csr_hazard_csr_bank.sv
// Six machine CSRs with a bulk write enable and a combinational debug read.
// Ports: csr_clk/rstn (sync active-low), csr_we, *_din next values,
// *_dout register contents, csr_debug_addr/csr_debug_dout debug read port.
module pcu_csr_hazard_csr_bank
  import pcu_csr_hazard_pkg::*;
(
  input  logic            csr_clk,
  input  logic            rstn,
  input  logic            csr_we,
  input  logic [XLEN-1:0] mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din,
  output logic [XLEN-1:0] mtevc_dout, mcause_dout, mepc_dout, mtval_dout, mipd_dout, bs_dout,
  input  logic [11:0]     csr_debug_addr,
  output logic [XLEN-1:0] csr_debug_dout
);

  logic [XLEN-1:0] mtevc_r, mcause_r, mepc_r, mtval_r, mipd_r, bs_r;
  logic [XLEN-1:0] debug_s;

  // CSR registers: clear on reset, load all on csr_we, otherwise hold.
  always_ff @(posedge csr_clk) begin
    if (!rstn) begin
      mtevc_r  <= {XLEN{1'b0}};
      mcause_r <= {XLEN{1'b0}};
      mepc_r   <= {XLEN{1'b0}};
      mtval_r  <= {XLEN{1'b0}};
      mipd_r   <= {XLEN{1'b0}};
      bs_r     <= {XLEN{1'b0}};
    end else if (csr_we) begin
      mtevc_r  <= mtevc_din;
      mcause_r <= mcause_din;
      mepc_r   <= mepc_din;
      mtval_r  <= mtval_din;
      mipd_r   <= mipd_din;
      bs_r     <= bs_din;
    end else begin
      mtevc_r  <= mtevc_r;
      mcause_r <= mcause_r;
      mepc_r   <= mepc_r;
      mtval_r  <= mtval_r;
      mipd_r   <= mipd_r;
      bs_r     <= bs_r;
    end
  end

  // Debug read mux; unmapped addresses return zero.
  always_comb begin
    debug_s = {XLEN{1'b0}};
    case (csr_debug_addr)
      CSR_MTEVC:  debug_s = mtevc_r;
      CSR_MCAUSE: debug_s = mcause_r;
      CSR_MEPC:   debug_s = mepc_r;
      CSR_MTVAL:  debug_s = mtval_r;
      CSR_MIPD:   debug_s = mipd_r;
      CSR_BS:     debug_s = bs_r;
      default:    debug_s = {XLEN{1'b0}};
    endcase
  end

  assign mtevc_dout     = mtevc_r;
  assign mcause_dout    = mcause_r;
  assign mepc_dout      = mepc_r;
  assign mtval_dout     = mtval_r;
  assign mipd_dout      = mipd_r;
  assign bs_dout        = bs_r;
  assign csr_debug_dout = debug_s;

endmodule

// File: rtl/pcu_csr_hazard.sv
// PCU storage and hazard core: CSR bank plus forwarding selects,
// load-use stall and control-flow flush.
// Ports: csr_clk, rstn (sync active-low, CSR bank only), bus (slave modport
// of pcu_csr_hazard_if carrying CSR, pipeline-word and hazard signals).
module pcu_csr_hazard
  import pcu_csr_hazard_pkg::*;
(
  input  logic            csr_clk,
  input  logic            rstn,
  pcu_csr_hazard_if.slave bus
);

  fwd_sel_e rs1_src_s, rs2_src_s;
  logic [6:0] ex_op_s;
  logic       ex_csr_reg_s;
  logic       load_use_s;
  logic       redirect_s;

  pcu_csr_hazard_csr_bank u_csr_bank (
    .csr_clk        (csr_clk),
    .rstn           (rstn),
    .csr_we         (bus.csr_we),
    .mtevc_din      (bus.mtevc_din),
    .mcause_din     (bus.mcause_din),
    .mepc_din       (bus.mepc_din),
    .mtval_din      (bus.mtval_din),
    .mipd_din       (bus.mipd_din),
    .bs_din         (bus.bs_din),
    .mtevc_dout     (bus.mtevc_dout),
    .mcause_dout    (bus.mcause_dout),
    .mepc_dout      (bus.mepc_dout),
    .mtval_dout     (bus.mtval_dout),
    .mipd_dout      (bus.mipd_dout),
    .bs_dout        (bus.bs_dout),
    .csr_debug_addr (bus.csr_debug_addr),
    .csr_debug_dout (bus.csr_debug_dout)
  );

  // Forward selects: locate the producer of each EX source, then gate by
  // whether the EX instruction really consumes that operand in that role.
  always_comb begin
    ex_op_s      = bus.ex_is[6:0];
    ex_csr_reg_s = (ex_op_s == OPC_SYSTEM) && (bus.ex_is[14:12] inside {3'd1, 3'd2, 3'd3});
    rs1_src_s    = fwd_pick(bus.mem_is, bus.wb_is, bus.ex_is[19:15]);
    rs2_src_s    = fwd_pick(bus.mem_is, bus.wb_is, bus.ex_is[24:20]);

    bus.sr1_mux_sel_fh    = FWD_RF;
    bus.sr2_mux_sel_fh    = FWD_RF;
    bus.b_sr1_mux_sel_fh  = FWD_RF;
    bus.b_sr2_mux_sel_fh  = FWD_RF;
    bus.dm_sr2_mux_sel_fh = FWD_RF;
    bus.csr_mux_sel_fh    = FWD_RF;

    if (ex_op_s inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_BRANCH}) begin
      bus.sr1_mux_sel_fh = rs1_src_s;
    end else begin
      bus.sr1_mux_sel_fh = FWD_RF;
    end

    if (ex_op_s == OPC_OP) begin
      bus.sr2_mux_sel_fh = rs2_src_s;
    end else begin
      bus.sr2_mux_sel_fh = FWD_RF;
    end

    if (ex_op_s == OPC_BRANCH) begin
      bus.b_sr1_mux_sel_fh = rs1_src_s;
      bus.b_sr2_mux_sel_fh = rs2_src_s;
    end else begin
      bus.b_sr1_mux_sel_fh = FWD_RF;
      bus.b_sr2_mux_sel_fh = FWD_RF;
    end

    if (ex_op_s == OPC_STORE) begin
      bus.dm_sr2_mux_sel_fh = rs2_src_s;
    end else begin
      bus.dm_sr2_mux_sel_fh = FWD_RF;
    end

    if (ex_csr_reg_s) begin
      bus.csr_mux_sel_fh = rs1_src_s;
    end else begin
      bus.csr_mux_sel_fh = FWD_RF;
    end
  end

  // Pipeline control: a redirect flushes ID/EX and must keep fetching,
  // so it takes priority over the load-use bubble.
  always_comb begin
    redirect_s = (bus.npc_mux_sel != 3'b000);
    load_use_s = (bus.ex_is[6:0] == OPC_LOAD) && (bus.ex_is[11:7] != 5'd0) &&
                 ((reads_rs1(bus.id_is) && (bus.id_is[19:15] == bus.ex_is[11:7])) ||
                  (reads_rs2(bus.id_is) && (bus.id_is[24:20] == bus.ex_is[11:7])));
    bus.pc_en       = 1'b1;
    bus.if_id_en    = 1'b1;
    bus.id_ex_clear = 1'b0;
    if (redirect_s) begin
      bus.pc_en       = 1'b1;
      bus.if_id_en    = 1'b1;
      bus.id_ex_clear = 1'b1;
    end else if (load_use_s) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_clear = 1'b1;
    end else begin
      bus.pc_en       = 1'b1;
      bus.if_id_en    = 1'b1;
      bus.id_ex_clear = 1'b0;
    end
  end

endmodule

// File: tb/tb_pcu_csr_hazard.sv
// Scoreboard bench for pcu_csr_hazard: stimulus pushes expected values,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pcu_csr_hazard;

  typedef enum logic [4:0] {
    K_MTEVC, K_MCAUSE, K_MEPC, K_MTVAL, K_MIPD, K_BS, K_DBG,
    K_SR1, K_SR2, K_BSR1, K_BSR2, K_DMSR2, K_CSR, K_PCEN, K_IFID, K_CLR
  } chk_e;

  typedef struct {
    chk_e        kind;
    logic [31:0] exp;
  } chk_t;

  logic csr_clk;
  logic rstn;
  pcu_csr_hazard_if bus();

  pcu_csr_hazard dut (
    .csr_clk (csr_clk),
    .rstn    (rstn),
    .bus     (bus.slave)
  );

  chk_t exp_q[$];
  chk_t mon_e;
  logic [31:0] mon_act;
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial csr_clk = 1'b0;
  always #5 csr_clk = ~csr_clk;

  // Monitor: compare every pending expectation while inputs are stable.
  always @(negedge csr_clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e.kind)
        K_MTEVC:  mon_act = bus.mtevc_dout;
        K_MCAUSE: mon_act = bus.mcause_dout;
        K_MEPC:   mon_act = bus.mepc_dout;
        K_MTVAL:  mon_act = bus.mtval_dout;
        K_MIPD:   mon_act = bus.mipd_dout;
        K_BS:     mon_act = bus.bs_dout;
        K_DBG:    mon_act = bus.csr_debug_dout;
        K_SR1:    mon_act = {29'd0, bus.sr1_mux_sel_fh};
        K_SR2:    mon_act = {29'd0, bus.sr2_mux_sel_fh};
        K_BSR1:   mon_act = {29'd0, bus.b_sr1_mux_sel_fh};
        K_BSR2:   mon_act = {29'd0, bus.b_sr2_mux_sel_fh};
        K_DMSR2:  mon_act = {29'd0, bus.dm_sr2_mux_sel_fh};
        K_CSR:    mon_act = {29'd0, bus.csr_mux_sel_fh};
        K_PCEN:   mon_act = {31'd0, bus.pc_en};
        K_IFID:   mon_act = {31'd0, bus.if_id_en};
        K_CLR:    mon_act = {31'd0, bus.id_ex_clear};
        default:  mon_act = 32'hxxxx_xxxx;
      endcase
      n_checks++;
      if (mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s at %0t: got 0x%08h expected 0x%08h",
                 mon_e.kind.name(), $time, mon_act, mon_e.exp);
      end
    end
  end

  task automatic step();
    @(posedge csr_clk);
    #1;
  endtask

  task automatic push(input chk_e k, input logic [31:0] e);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    exp_q.push_back(c);
  endtask

  task automatic set_din(input logic [31:0] a, b, c, d, e, f);
    bus.mtevc_din  = a;
    bus.mcause_din = b;
    bus.mepc_din   = c;
    bus.mtval_din  = d;
    bus.mipd_din   = e;
    bus.bs_din     = f;
  endtask

  task automatic exp_csrs(input logic [31:0] a, b, c, d, e, f);
    push(K_MTEVC, a);  push(K_MCAUSE, b); push(K_MEPC, c);
    push(K_MTVAL, d);  push(K_MIPD, e);   push(K_BS, f);
  endtask

  task automatic set_pipe(input logic [31:0] id, ex, mem, wb, input logic [2:0] npc);
    bus.id_is       = id;
    bus.ex_is       = ex;
    bus.mem_is      = mem;
    bus.wb_is       = wb;
    bus.npc_mux_sel = npc;
  endtask

  // Expected: sr1, sr2, b_sr1, b_sr2, dm_sr2, csr, pc_en, if_id_en, id_ex_clear.
  task automatic exp_haz(input int s1, s2, b1, b2, dm, cs, input logic pe, ie, cl);
    push(K_SR1, s1);   push(K_SR2, s2);   push(K_BSR1, b1);
    push(K_BSR2, b2);  push(K_DMSR2, dm); push(K_CSR, cs);
    push(K_PCEN, {31'd0, pe}); push(K_IFID, {31'd0, ie}); push(K_CLR, {31'd0, cl});
    step();
  endtask

  initial begin
    rstn   = 1'b0;
    bus.csr_we = 1'b0;
    bus.csr_debug_addr = 12'h000;
    set_din(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_pipe(NOP, NOP, NOP, NOP, 3'b000);
    step();
    step();
    rstn = 1'b1;

    // Reset state.
    exp_csrs(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();

    // Single mepc write, visible one cycle later.
    bus.mepc_din = 32'h0000_1234;
    bus.csr_we   = 1'b1;
    step();
    bus.csr_we   = 1'b0;
    bus.csr_debug_addr = 12'h341;
    push(K_MEPC, 32'h0000_1234);
    push(K_DBG,  32'h0000_1234);
    step();
    bus.csr_debug_addr = 12'h7FF;
    push(K_DBG, 32'd0);
    step();

    // Write all six, then walk the debug map.
    set_din(32'h0000_305A, 32'h8000_0007, 32'h0000_4444, 32'hDEAD_BEEF, 32'h0000_0080, 32'h0000_0003);
    bus.csr_we = 1'b1;
    step();
    bus.csr_we = 1'b0;
    exp_csrs(32'h0000_305A, 32'h8000_0007, 32'h0000_4444, 32'hDEAD_BEEF, 32'h0000_0080, 32'h0000_0003);
    step();
    bus.csr_debug_addr = 12'h305; push(K_DBG, 32'h0000_305A); step();
    bus.csr_debug_addr = 12'h342; push(K_DBG, 32'h8000_0007); step();
    bus.csr_debug_addr = 12'h343; push(K_DBG, 32'hDEAD_BEEF); step();
    bus.csr_debug_addr = 12'h100; push(K_DBG, 32'h0000_0080); step();
    bus.csr_debug_addr = 12'h000; push(K_DBG, 32'h0000_0003); step();
    bus.csr_debug_addr = 12'h344; push(K_DBG, 32'd0);         step();

    // Hold with csr_we low while din changes.
    set_din(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666);
    step();
    step();
    exp_csrs(32'h0000_305A, 32'h8000_0007, 32'h0000_4444, 32'hDEAD_BEEF, 32'h0000_0080, 32'h0000_0003);
    step();

    // One reset edge clears everything even with csr_we high.
    bus.csr_we = 1'b1;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    bus.csr_we = 1'b0;
    exp_csrs(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    step();

    // add x6,x5,x5 with x5 in MEM and WB: MEM wins.
    set_pipe(NOP, 32'h0052_8333, 32'h0010_0293, 32'h0020_0293, 3'b000);
    exp_haz(1, 1, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    // Same with MEM bubble: WB forwards.
    set_pipe(NOP, 32'h0052_8333, NOP, 32'h0020_0293, 3'b000);
    exp_haz(2, 2, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    // Load in MEM (lw x5) is not a source: WB forwards.
    set_pipe(NOP, 32'h0052_8333, 32'h0000_A283, 32'h0020_0293, 3'b000);
    exp_haz(2, 2, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    // Redirect alone: flush but keep fetching.
    set_pipe(NOP, 32'h0052_8333, 32'h0010_0293, 32'h0020_0293, 3'b100);
    exp_haz(1, 1, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    // Load-use: lw x7 in EX, add x8,x7,x2 in ID.
    set_pipe(32'h0023_8433, 32'h0000_A383, NOP, NOP, 3'b000);
    exp_haz(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    // Redirect overrides the stall.
    set_pipe(32'h0023_8433, 32'h0000_A383, NOP, NOP, 3'b001);
    exp_haz(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
    // lw x0 never stalls.
    set_pipe(32'h0023_8033, 32'h0000_A003, NOP, NOP, 3'b000);
    exp_haz(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    // lui x7 in ID reads no register: no stall.
    set_pipe(32'h0000_13B7, 32'h0000_A383, NOP, NOP, 3'b000);
    exp_haz(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    // sw x9,0(x10) with x9 in MEM: store data forwards, ALU rs2 does not.
    set_pipe(NOP, 32'h0095_2023, 32'h0070_0493, NOP, 3'b000);
    exp_haz(0, 0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0);
    // beq x9,x0 with x9 in MEM.
    set_pipe(NOP, 32'h0004_8063, 32'h0070_0493, NOP, 3'b000);
    exp_haz(1, 0, 1, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    // Writers to x0 and consumer of x0: nothing forwards.
    set_pipe(NOP, 32'h0000_0333, 32'h0050_0013, 32'h0050_0013, 3'b000);
    exp_haz(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    // csrrw x0,0x100,x4 with x4 written in WB.
    set_pipe(NOP, 32'h1002_1073, NOP, 32'h0030_0213, 3'b000);
    exp_haz(0, 0, 0, 0, 0, 2, 1'b1, 1'b1, 1'b0);

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
